// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for a single-port word memory: round-robin grant,
// byte-store read-modify-write, byte-load sign extension. Optional DMEM_ARB_FIXED_PRIORITY_EN.

module dmem_arbiter_lane (
    input  logic       sel,
    input  logic [7:0] old_byte,
    input  logic [7:0] new_byte,
    output logic [7:0] merged
);
    assign merged = sel ? new_byte : old_byte;
endmodule

module dmem_arbiter #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        r0_req,
    input  logic        r0_we,
    input  logic        r0_byte,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    output logic        r0_done,
    output logic        r0_err,
    output logic [31:0] r0_rdata,
    input  logic        r1_req,
    input  logic        r1_we,
    input  logic        r1_byte,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r1_done,
    output logic        r1_err,
    output logic [31:0] r1_rdata,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);
    localparam int          NUM_LANES = 4;
    localparam logic [29:0] DEPTH_IDX = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, ACCESS, RMW_WR, DONE} state_t;

    state_t      state;
    logic        gnt_id;
    logic        op_we;
    logic        op_byte;
    logic        op_oor;
    logic [1:0]  op_lane;
    logic [7:0]  op_wbyte;
`ifndef DMEM_ARB_FIXED_PRIORITY_EN
    logic        last_gnt;
`endif

    logic        any_req;
    logic        pick;
    logic        sel_we;
    logic        sel_byte;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_oor;

    logic [NUM_LANES-1:0][7:0] rd_lanes;
    logic [NUM_LANES-1:0][7:0] rmw_lanes;
    logic [7:0]  ld_byte;
    logic [31:0] load_val;

    assign any_req = r0_req | r1_req;

    always_comb begin
        pick = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIORITY_EN
        pick = ~r0_req;
`else
        if (r0_req && r1_req) pick = ~last_gnt;
        else                  pick = ~r0_req;
`endif
    end

    assign sel_we    = pick ? r1_we    : r0_we;
    assign sel_byte  = pick ? r1_byte  : r0_byte;
    assign sel_addr  = pick ? r1_addr  : r0_addr;
    assign sel_wdata = pick ? r1_wdata : r0_wdata;
    assign sel_oor   = (sel_addr[31:2] >= DEPTH_IDX);

    // Memory read data is live during ACCESS; both the RMW merge and the load
    // extraction are taken from it in that cycle.
    assign rd_lanes = mem_rd;

    for (genvar ln = 0; ln < NUM_LANES; ln++) begin : g_lane
        dmem_arbiter_lane u_lane (
            .sel      (op_lane == 2'(ln)),
            .old_byte (rd_lanes[ln]),
            .new_byte (op_wbyte),
            .merged   (rmw_lanes[ln])
        );
    end

    assign ld_byte  = rd_lanes[op_lane];
    assign load_val = op_byte ? {{24{ld_byte[7]}}, ld_byte} : mem_rd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            gnt_id   <= 1'b0;
            op_we    <= 1'b0;
            op_byte  <= 1'b0;
            op_oor   <= 1'b0;
            op_lane  <= 2'b00;
            op_wbyte <= 8'h00;
`ifndef DMEM_ARB_FIXED_PRIORITY_EN
            last_gnt <= 1'b1;
`endif
            mem_we   <= 1'b0;
            mem_a    <= 32'h0;
            mem_wd   <= 32'h0;
            r0_done  <= 1'b0;
            r0_err   <= 1'b0;
            r0_rdata <= 32'h0;
            r1_done  <= 1'b0;
            r1_err   <= 1'b0;
            r1_rdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_id   <= pick;
`ifndef DMEM_ARB_FIXED_PRIORITY_EN
                        last_gnt <= pick;
`endif
                        op_we    <= sel_we;
                        op_byte  <= sel_byte;
                        op_oor   <= sel_oor;
                        op_lane  <= sel_addr[1:0];
                        op_wbyte <= sel_wdata[7:0];
                        mem_a    <= {sel_addr[31:2], 2'b00};
                        mem_wd   <= sel_wdata;
                        // Only an in-range word store writes in ACCESS.
                        mem_we   <= sel_we & ~sel_byte & ~sel_oor;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we <= 1'b0;
                    if (!op_oor && op_we && op_byte) begin
                        mem_we <= 1'b1;
                        mem_wd <= rmw_lanes;
                        state  <= RMW_WR;
                    end else begin
                        r0_done <= ~gnt_id;
                        r1_done <= gnt_id;
                        if (op_oor) begin
                            r0_err <= ~gnt_id;
                            r1_err <= gnt_id;
                        end else if (!op_we) begin
                            if (gnt_id) r1_rdata <= load_val;
                            else        r0_rdata <= load_val;
                        end
                        state <= DONE;
                    end
                end
                RMW_WR: begin
                    mem_we  <= 1'b0;
                    r0_done <= ~gnt_id;
                    r1_done <= gnt_id;
                    state   <= DONE;
                end
                DONE: begin
                    r0_done  <= 1'b0;
                    r1_done  <= 1'b0;
                    r0_err   <= 1'b0;
                    r1_err   <= 1'b0;
                    r0_rdata <= 32'h0;
                    r1_rdata <= 32'h0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 64-word memory attached.

module tb_dmem_arbiter;
    logic        clk;
    logic        reset;
    logic        r0_req, r0_we, r0_byte;
    logic [31:0] r0_addr, r0_wdata;
    logic        r0_done, r0_err;
    logic [31:0] r0_rdata;
    logic        r1_req, r1_we, r1_byte;
    logic [31:0] r1_addr, r1_wdata;
    logic        r1_done, r1_err;
    logic [31:0] r1_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    logic [31:0] mem [0:63];
    int          checks = 0;
    int          errors = 0;
    int          we_cnt = 0;
    int          we_run = 0;
    int          we_run_max = 0;
    logic [31:0] last_wa = 32'h0;
    logic [31:0] last_wd = 32'h0;

    dmem_arbiter #(.DEPTH_WORDS(64)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_byte(r0_byte), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_done(r0_done), .r0_err(r0_err), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_byte(r1_byte), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_done(r1_done), .r1_err(r1_err), .r1_rdata(r1_rdata),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = (mem_a[31:8] == 24'h0) ? mem[mem_a[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            if (mem_a[31:8] == 24'h0) mem[mem_a[7:2]] <= mem_wd;
            we_cnt  = we_cnt + 1;
            last_wa = mem_a;
            last_wd = mem_wd;
            we_run  = we_run + 1;
            if (we_run > we_run_max) we_run_max = we_run;
        end else begin
            we_run = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Latency counts the IDLE cycle that samples req as cycle 1.
    task automatic do_op(input int p, input logic we, input logic by,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat);
        int   cyc;
        logic seen;
        @(negedge clk);
        we_cnt = 0;
        if (p == 0) begin
            r0_we = we; r0_byte = by; r0_addr = addr; r0_wdata = wd; r0_req = 1'b1;
        end else begin
            r1_we = we; r1_byte = by; r1_addr = addr; r1_wdata = wd; r1_req = 1'b1;
        end
        cyc = 1; seen = 1'b0; rd = 32'h0; er = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (((p == 0) ? r0_done : r1_done) === 1'b1) begin
                seen = 1'b1;
                rd   = (p == 0) ? r0_rdata : r1_rdata;
                er   = (p == 0) ? r0_err : r1_err;
            end
        end
        r0_req = 1'b0;
        r1_req = 1'b0;
        lat = cyc;
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n;
        logic [3:0]  ord;
        logic [3:0]  ord_exp;

        reset = 1'b1;
        r0_req = 1'b0; r0_we = 1'b0; r0_byte = 1'b0; r0_addr = 32'h0; r0_wdata = 32'h0;
        r1_req = 1'b0; r1_we = 1'b0; r1_byte = 1'b0; r1_addr = 32'h0; r1_wdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_dones", {30'h0, r1_done, r0_done}, 32'h0);
        chk("rst_errs", {30'h0, r1_err, r0_err}, 32'h0);
        chk("rst_r0_rdata", r0_rdata, 32'h0);
        reset = 1'b0;

        // Word store then load on port 0
        do_op(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
        chk("wst_lat", 32'(lat), 32'd3);
        chk("wst_we_cnt", 32'(we_cnt), 32'd1);
        chk("wst_addr", last_wa, 32'h10);
        chk("wst_data", last_wd, 32'hDEADBEEF);
        chk("wst_err", 32'(er), 32'd0);
        do_op(0, 1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat);
        chk("wld_data", rd, 32'hDEADBEEF);
        chk("wld_lat", 32'(lat), 32'd3);
        chk("wld_no_write", 32'(we_cnt), 32'd0);

        // Byte store RMW on port 1
        do_op(1, 1'b1, 1'b0, 32'h20, 32'h11223344, rd, er, lat);
        do_op(1, 1'b1, 1'b1, 32'h22, 32'hFFFFFFAB, rd, er, lat);
        chk("bst_lat", 32'(lat), 32'd4);
        chk("bst_we_cnt", 32'(we_cnt), 32'd1);
        chk("bst_addr", last_wa, 32'h20);
        chk("bst_data", last_wd, 32'h11AB3344);
        chk("bst_mem", mem[8], 32'h11AB3344);
        chk("bst_rdata", rd, 32'h0);

        // Byte load sign extension
        do_op(0, 1'b1, 1'b0, 32'h30, 32'h00F00080, rd, er, lat);
        do_op(0, 1'b0, 1'b1, 32'h30, 32'h0, rd, er, lat);
        chk("bld_lane0", rd, 32'hFFFFFF80);
        do_op(0, 1'b0, 1'b1, 32'h32, 32'h0, rd, er, lat);
        chk("bld_lane2", rd, 32'hFFFFFFF0);
        do_op(1, 1'b0, 1'b1, 32'h31, 32'h0, rd, er, lat);
        chk("bld_lane1", rd, 32'h00000000);
        chk("bld_lat", 32'(lat), 32'd3);
        do_op(1, 1'b0, 1'b0, 32'h33, 32'h0, rd, er, lat);
        chk("wld_unaligned", rd, 32'h00F00080);

        // Out of range
        do_op(0, 1'b1, 1'b0, 32'h100, 32'hCAFEF00D, rd, er, lat);
        chk("oor_st_we", 32'(we_cnt), 32'd0);
        chk("oor_st_err", 32'(er), 32'd1);
        chk("oor_st_rdata", rd, 32'h0);
        chk("oor_st_lat", 32'(lat), 32'd3);
        do_op(1, 1'b0, 1'b0, 32'h104, 32'h0, rd, er, lat);
        chk("oor_ld_err", 32'(er), 32'd1);
        chk("oor_ld_rdata", rd, 32'h0);

        // Contention: both held high; last grant went to port 1
        @(negedge clk);
        r0_we = 1'b0; r0_byte = 1'b0; r0_addr = 32'h10; r0_req = 1'b1;
        r1_we = 1'b0; r1_byte = 1'b0; r1_addr = 32'h20; r1_req = 1'b1;
        n = 0; ord = 4'h0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (r0_done === 1'b1) begin
                chk("cont_r0_rdata", r0_rdata, 32'hDEADBEEF);
                ord[n] = 1'b0; n++;
            end else if (r1_done === 1'b1) begin
                chk("cont_r1_rdata", r1_rdata, 32'h11AB3344);
                ord[n] = 1'b1; n++;
            end
        end
        r0_req = 1'b0; r1_req = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIORITY_EN
        ord_exp = 4'b0000;
`else
        ord_exp = 4'b1010;
`endif
        chk("cont_count", 32'(n), 32'd4);
        chk("cont_order", {28'h0, ord}, {28'h0, ord_exp});

        // Reset during RMW_WR of a port-0 byte store
        @(negedge clk);
        @(negedge clk);
        r0_we = 1'b1; r0_byte = 1'b1; r0_addr = 32'h20; r0_wdata = 32'h00000055; r0_req = 1'b1;
        @(negedge clk);
        chk("rmw_access_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        chk("rmw_wr_we", 32'(mem_we), 32'd1);
        chk("rmw_wr_data", mem_wd, 32'h11AB3355);
        #1 reset = 1'b1;
        #1;
        chk("rst_async_we", 32'(mem_we), 32'd0);
        chk("rst_async_done", {30'h0, r1_done, r0_done}, 32'h0);
        r0_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mem_kept", mem[8], 32'h11AB3344);

        // Tie after reset goes to port 0
        r0_we = 1'b0; r0_byte = 1'b0; r0_addr = 32'h10; r0_req = 1'b1;
        r1_we = 1'b0; r1_byte = 1'b0; r1_addr = 32'h20; r1_req = 1'b1;
        n = -1;
        for (int c = 0; c < 20 && n < 0; c++) begin
            @(negedge clk);
            if (r0_done === 1'b1)      n = 0;
            else if (r1_done === 1'b1) n = 1;
        end
        r0_req = 1'b0; r1_req = 1'b0;
        chk("post_rst_tie", 32'(n), 32'd0);
        chk("we_run_max", 32'(we_run_max), 32'd1);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
